dmem_stage_p: RTL and testbench

Parametrised data-memory pipeline stage for the RISC core, sitting between the execute stage and register writeback.
- Owns a word-addressed on-chip data RAM.
- Performs conditional LDR/STR with pre/post-indexing and base writeback.
- Generalises the fixed 16-bit single-cycle memory stage: configurable width, depth and access latency, valid/ready handshake, out-of-range fault reporting.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_stage_p_if.sv | 61 ++++++
 rtl/dmem_ram.sv | 35 +++
 rtl/dmem_stage_p.sv | 194 +++++++++++++++++++
 tb/tb_dmem_stage_p.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory pipeline stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_HOLD
  } state_e;

  // A store whose source is the PC sees the PC eight bytes plus one word ahead.
  localparam int unsigned PC_STORE_ADJ = 12;

  // U bit: 1 adds the offset, 0 subtracts it; callers truncate to their width.
  function automatic logic [31:0] apply_offset(input logic [31:0] base,
                                               input logic [31:0] offs,
                                               input logic        up);
    return up ? (base + offs) : (base - offs);
  endfunction

endpackage

// File: rtl/dmem_stage_p_if.sv
// Request/result bundle of the data-memory stage. DMEM_BYTE_EN adds byte-lane controls.
interface dmem_stage_p_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OFFS_W = 12
);
  localparam int unsigned LANE_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_cond;
  logic              in_ls;
  logic              in_load;
  logic              in_pre;
  logic              in_up;
  logic              in_wb;
  logic              in_rn_pc;
  logic              in_rd_pc;
  logic [ADDR_W-1:0] base_addr;
  logic [OFFS_W-1:0] offset;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] alu_in;
  logic [DATA_W-1:0] instr_in;
`ifdef DMEM_BYTE_EN
  logic              in_byte;
  logic [LANE_W-1:0] in_lane;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] load_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic              cond_out;
  logic              ls_out;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] instr_out;
  logic              fault;

  modport slave (
`ifdef DMEM_BYTE_EN
    input  in_byte, in_lane,
`endif
    input  in_valid, in_cond, in_ls, in_load, in_pre, in_up, in_wb,
           in_rn_pc, in_rd_pc, base_addr, offset, store_data, alu_in,
           instr_in, out_ready,
    output in_ready, out_valid, load_data, wb_en, wb_addr, cond_out,
           ls_out, alu_out, instr_out, fault
  );

  modport master (
`ifdef DMEM_BYTE_EN
    output in_byte, in_lane,
`endif
    output in_valid, in_cond, in_ls, in_load, in_pre, in_up, in_wb,
           in_rn_pc, in_rd_pc, base_addr, offset, store_data, alu_in,
           instr_in, out_ready,
    input  in_ready, out_valid, load_data, wb_en, wb_addr, cond_out,
           ls_out, alu_out, instr_out, fault
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port data RAM: synchronous write (optionally per byte lane), asynchronous read.
module dmem_ram #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 8,
  parameter bit          BYTE_WR = 1'b0,
  parameter int unsigned NB      = BYTE_WR ? DATA_W / 8 : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  if (BYTE_WR) begin : g_byte
    always_ff @(posedge clk) begin
      if (we) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end else begin : g_word
    always_ff @(posedge clk) begin
      if (we && be[0]) mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_stage_p.sv
// Data-memory pipeline stage: conditional LDR/STR with pre/post-indexing and base writeback.
// Optional byte accesses are enabled by defining DMEM_BYTE_EN.
module dmem_stage_p
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned OFFS_W  = 12,
  parameter int unsigned ACC_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  dmem_stage_p_if.slave  bus
);

  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LANE_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;
`ifdef DMEM_BYTE_EN
  localparam bit          BYTE_WR = 1'b1;
`else
  localparam bit          BYTE_WR = 1'b0;
`endif
  localparam int unsigned NB      = BYTE_WR ? DATA_W / 8 : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              load_q, load_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic              byte_q, byte_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              cond_q, cond_d;
  logic              ls_q, ls_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] ea, acc_addr;
  logic              in_range;
  logic              ram_we;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, rd_sel;
  logic              req_byte;
  logic [LANE_W-1:0] req_lane;

  assign ea       = ADDR_W'(apply_offset(32'(bus.base_addr), 32'(bus.offset), bus.in_up));
  assign acc_addr = bus.in_pre ? ea : bus.base_addr;
  assign in_range = {1'b0, acc_addr} < DEPTH_L;

`ifdef DMEM_BYTE_EN
  assign req_byte  = bus.in_byte;
  assign req_lane  = bus.in_lane;
  // Byte stores replicate the byte across lanes and let the enable pick one.
  assign ram_wdata = byte_q ? {NB{sdata_q[7:0]}} : sdata_q;
  assign ram_be    = byte_q ? NB'(1) << lane_q : '1;
  assign rd_sel    = byte_q ? DATA_W'(ram_rdata[{lane_q, 3'b000} +: 8]) : ram_rdata;
`else
  assign req_byte  = 1'b0;
  assign req_lane  = '0;
  assign ram_wdata = sdata_q;
  assign ram_be    = '1;
  assign rd_sel    = ram_rdata;
`endif

  dmem_ram #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AW      (RAM_AW),
    .BYTE_WR (BYTE_WR),
    .NB      (NB)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (addr_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    byte_d    = byte_q;
    lane_d    = lane_q;
    ld_d      = ld_q;
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    cond_d    = cond_q;
    ls_d      = ls_q;
    alu_d     = alu_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    ram_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          cond_d    = bus.in_cond;
          ls_d      = bus.in_ls;
          alu_d     = bus.alu_in;
          instr_d   = bus.instr_in;
          wb_addr_d = ea;
          load_d    = bus.in_load;
          addr_d    = acc_addr[RAM_AW-1:0];
          sdata_d   = bus.in_rd_pc ? bus.store_data + DATA_W'(PC_STORE_ADJ) : bus.store_data;
          byte_d    = req_byte;
          lane_d    = req_lane;
          wb_en_d   = 1'b0;
          fault_d   = 1'b0;
          state_d   = ST_HOLD;
          if (bus.in_ls && bus.in_cond) begin
            if (in_range) begin
              wb_en_d = bus.in_wb & ~bus.in_rn_pc;
              cnt_d   = 2'(ACC_LAT - 1);
              state_d = ST_ACCESS;
            end else begin
              fault_d = 1'b1;
              ld_d    = '0;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (load_q) ld_d = rd_sel;
          else        ram_we = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      sdata_q   <= '0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
      ld_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      cond_q    <= 1'b0;
      ls_q      <= 1'b0;
      alu_q     <= '0;
      instr_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      byte_q    <= byte_d;
      lane_q    <= lane_d;
      ld_q      <= ld_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      cond_q    <= cond_d;
      ls_q      <= ls_d;
      alu_q     <= alu_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.load_data = ld_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.cond_out  = cond_q;
  assign bus.ls_out    = ls_q;
  assign bus.alu_out   = alu_q;
  assign bus.instr_out = instr_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_dmem_stage_p.sv
// Directed bench for dmem_stage_p with a 9-bit address, 256-word RAM and 3-cycle access.
module tb_dmem_stage_p;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 9;
  localparam int unsigned OW  = 12;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_stage_p_if #(.DATA_W(DW), .ADDR_W(AW), .OFFS_W(OW)) bus ();

  dmem_stage_p #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DEPTH   (256),
    .OFFS_W  (OW),
    .ACC_LAT (LAT)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic ld, input logic pre, input logic up, input logic wb,
                     input logic [AW-1:0] base, input logic [OW-1:0] off,
                     input logic [DW-1:0] sd);
    bus.in_cond    = 1'b1;
    bus.in_ls      = 1'b1;
    bus.in_load    = ld;
    bus.in_pre     = pre;
    bus.in_up      = up;
    bus.in_wb      = wb;
    bus.in_rn_pc   = 1'b0;
    bus.in_rd_pc   = 1'b0;
    bus.base_addr  = base;
    bus.offset     = off;
    bus.store_data = sd;
`ifdef DMEM_BYTE_EN
    bus.in_byte    = 1'b0;
    bus.in_lane    = '0;
`endif
  endtask

  // lat = rising edges after the transfer edge until out_valid is seen (20 = timeout).
  task automatic xfer(output int lat);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && g < 20) begin
      @(posedge clk); #1; g++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic store_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat;
    req(1'b0, 1'b1, 1'b1, 1'b0, a, '0, d);
    xfer(lat);
    release_out();
  endtask

  task automatic load_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int lat;
    req(1'b1, 1'b1, 1'b1, 1'b0, a, '0, '0);
    xfer(lat);
    chk(tag, bus.load_data, exp);
    release_out();
  endtask

  initial begin
    int   lat;
    logic stable;

    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.alu_in     = '0;
    bus.instr_in   = '0;
    req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #22;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_load_data", bus.load_data, 32'd0);
    chk("rst_wb_en",     32'(bus.wb_en), 32'd0);
    chk("rst_fault",     32'(bus.fault), 32'd0);
    chk("rst_alu_out",   bus.alu_out, 32'd0);
    chk("rst_cond_ls",   {30'd0, bus.cond_out, bus.ls_out}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Pre-indexed store with writeback: address 0x14.
    req(1'b0, 1'b1, 1'b1, 1'b1, 9'h010, 12'h004, 32'hDEADBEEF);
    bus.alu_in   = 32'h0000_1234;
    bus.instr_in = 32'hE5A0_1004;
    xfer(lat);
    chk("st_latency",  32'(lat), 32'd3);
    chk("st_wb_en",    32'(bus.wb_en), 32'd1);
    chk("st_wb_addr",  32'(bus.wb_addr), 32'h014);
    chk("st_fault",    32'(bus.fault), 32'd0);
    chk("st_cond_ls",  {30'd0, bus.cond_out, bus.ls_out}, 32'd3);
    chk("st_alu_out",  bus.alu_out, 32'h0000_1234);
    chk("st_instr",    bus.instr_out, 32'hE5A0_1004);
    release_out();

    // Load back with out_ready held low for 5 cycles.
    req(1'b1, 1'b1, 1'b1, 1'b0, 9'h010, 12'h004, '0);
    xfer(lat);
    chk("ld_latency", 32'(lat), 32'd3);
    chk("ld_data",    bus.load_data, 32'hDEADBEEF);
    chk("ld_wb_en",   32'(bus.wb_en), 32'd0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.load_data !== 32'hDEADBEEF || bus.wb_addr !== 9'h014)
        stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    release_out();
    chk("idle_ready", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

    // Post-indexed load, subtract: reads 0x20, base becomes 0x18.
    store_word(9'h020, 32'h0BAD_F00D);
    req(1'b1, 1'b0, 1'b0, 1'b1, 9'h020, 12'h008, '0);
    xfer(lat);
    chk("post_data",    bus.load_data, 32'h0BAD_F00D);
    chk("post_wb_en",   32'(bus.wb_en), 32'd1);
    chk("post_wb_addr", 32'(bus.wb_addr), 32'h018);
    release_out();

    // Base is PC: writeback suppressed.
    req(1'b1, 1'b1, 1'b1, 1'b1, 9'h010, 12'h004, '0);
    bus.in_rn_pc = 1'b1;
    xfer(lat);
    chk("rnpc_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rnpc_data",  bus.load_data, 32'hDEADBEEF);
    release_out();

    // Store source is PC: value + 12.
    req(1'b0, 1'b1, 1'b1, 1'b0, 9'h030, '0, 32'h0000_0100);
    bus.in_rd_pc = 1'b1;
    xfer(lat);
    release_out();
    load_chk("rdpc_data", 9'h030, 32'h0000_010C);

    // Condition failed: no access, load_data keeps previous load.
    store_word(9'h005, 32'h0000_0077);
    req(1'b0, 1'b1, 1'b1, 1'b1, 9'h005, '0, 32'h0000_0055);
    bus.in_cond = 1'b0;
    bus.alu_in  = 32'h0000_A5A5;
    xfer(lat);
    chk("nc_latency",  32'(lat), 32'd0);
    chk("nc_cond_out", 32'(bus.cond_out), 32'd0);
    chk("nc_wb_en",    32'(bus.wb_en), 32'd0);
    chk("nc_ld_keep",  bus.load_data, 32'h0000_010C);
    chk("nc_alu_out",  bus.alu_out, 32'h0000_A5A5);
    release_out();
    load_chk("nc_ram", 9'h005, 32'h0000_0077);

    // Not a load/store: pass-through only.
    req(1'b1, 1'b1, 1'b1, 1'b1, 9'h005, '0, '0);
    bus.in_ls    = 1'b0;
    bus.alu_in   = 32'h0000_CAFE;
    bus.instr_in = 32'hE081_0002;
    xfer(lat);
    chk("nls_latency", 32'(lat), 32'd0);
    chk("nls_ls_out",  32'(bus.ls_out), 32'd0);
    chk("nls_alu",     bus.alu_out, 32'h0000_CAFE);
    chk("nls_wb_fault", {30'd0, bus.wb_en, bus.fault}, 32'd0);
    release_out();

    // Out of range 0x1F0 (aliases 0xF0 if truncated): fault, no write.
    store_word(9'h0F0, 32'h5A5A_5A5A);
    req(1'b0, 1'b1, 1'b1, 1'b1, 9'h1F0, '0, 32'hFFFF_FFFF);
    xfer(lat);
    chk("flt_st_latency", 32'(lat), 32'd0);
    chk("flt_st_fault",   32'(bus.fault), 32'd1);
    chk("flt_st_wb_en",   32'(bus.wb_en), 32'd0);
    chk("flt_st_ld",      bus.load_data, 32'd0);
    release_out();
    load_chk("flt_noalias", 9'h0F0, 32'h5A5A_5A5A);
    req(1'b1, 1'b0, 1'b1, 1'b0, 9'h1F0, '0, '0);
    xfer(lat);
    chk("flt_ld", {bus.load_data[30:0], bus.fault}, 32'd1);
    release_out();
    chk("flt_clear_fault", 32'(bus.fault), 32'd1);
    load_chk("ok_after_flt", 9'h0F0, 32'h5A5A_5A5A);
    chk("ok_fault", 32'(bus.fault), 32'd0);

    // Reset during ACCESS drops the pending store.
    store_word(9'h040, 32'h1234_5678);
    req(1'b0, 1'b1, 1'b1, 1'b1, 9'h040, '0, 32'h0000_0099);
    bus.alu_in   = 32'h0000_0BB0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {30'd0, bus.out_valid, bus.wb_en}, 32'd0);
    chk("mid_rst_alu",   bus.alu_out, 32'd0);
    chk("mid_rst_side",  {29'd0, bus.cond_out, bus.ls_out, bus.fault}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    load_chk("mid_rst_ram", 9'h040, 32'h1234_5678);

`ifdef DMEM_BYTE_EN
    store_word(9'h050, 32'h1122_3344);
    req(1'b0, 1'b1, 1'b1, 1'b0, 9'h050, '0, 32'h0000_00AA);
    bus.in_byte = 1'b1;
    bus.in_lane = 2'd2;
    xfer(lat);
    release_out();
    load_chk("byte_word", 9'h050, 32'h11AA_3344);
    req(1'b1, 1'b1, 1'b1, 1'b0, 9'h050, '0, '0);
    bus.in_byte = 1'b1;
    bus.in_lane = 2'd2;
    xfer(lat);
    chk("byte_load", bus.load_data, 32'h0000_00AA);
    release_out();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
